// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   MEM-stage data-memory access engine. Takes the registered access code,
//   effective address and store data from EX/MEM, issues one request/ack
//   transaction on a multi-cycle memory port, steers store bytes into lanes,
//   extracts and extends load lanes, and stalls the pipeline until the
//   transaction has completed or been aborted on timeout.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   read_write_in  {write, funct3} access code from EX/MEM
//   alu_result_in  effective byte address
//   read_data2_in  store data (rs2)
//   mem_req        request valid, held for the whole BUSY phase
//   mem_we         1 = write, 0 = read
//   mem_addr       word address (bits [1:0] zero)
//   mem_be         byte enables (lane mask)
//   mem_wdata      lane-steered store data
//   mem_ack        single-cycle completion pulse from memory
//   mem_rdata      read word, valid with mem_ack
//   load_data_out  extended load result to MEM/WB
//   stall_out      hold upstream pipeline registers
//   misalign_out   misaligned access presented in IDLE
//   bus_error_out  one-cycle pulse when a request times out
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  read_write_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] read_data2_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_data_out,
    output logic        stall_out,
    output logic        misalign_out,
    output logic        bus_error_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    // Lane mask for an access of the given size (code[1:0]) at byte offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Replicate the store operand across lanes; byte enables pick the lane.
    function automatic logic [31:0] steer_store(input logic [1:0] size, input logic [31:0] rs2);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{rs2[7:0]}};
            2'b01:   w = {2{rs2[15:0]}};
            default: w = rs2;
        endcase
        return w;
    endfunction

    // Pick the addressed byte/halfword and sign- or zero-extend it.
    function automatic logic [31:0] extract_load(input logic [31:0] rdata,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]  ld_f3_q, ld_f3_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic [31:0] load_data_q, load_data_d;
    logic        bus_err_q, bus_err_d;

    logic        valid_c;
    logic        misaligned_c;
    logic        access_ok_c;

    // Access decode (combinational on the EX/MEM outputs)
    always_comb begin
        valid_c = 1'b0;
        case (read_write_in)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
            4'b1000, 4'b1001, 4'b1010: valid_c = 1'b1;
            default:                   valid_c = 1'b0;
        endcase

        misaligned_c = 1'b0;
        case (read_write_in[1:0])
            2'b01:   misaligned_c = alu_result_in[0];
            2'b10:   misaligned_c = (alu_result_in[1:0] != 2'b00);
            default: misaligned_c = 1'b0;
        endcase
    end

    assign access_ok_c  = valid_c && !misaligned_c;
    assign misalign_out = (state_q == IDLE) && valid_c && misaligned_c;
    assign stall_out    = ((state_q == IDLE) && access_ok_c) || (state_q == BUSY);

    // Next-state and datapath register updates
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ld_f3_d     = ld_f3_q;
        ld_off_d    = ld_off_q;
        load_data_d = load_data_q;
        bus_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (access_ok_c) begin
                    state_d     = BUSY;
                    cnt_d       = 8'd0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = read_write_in[3];
                    mem_be_d    = lane_mask(read_write_in[1:0], alu_result_in[1:0]);
                    mem_addr_d  = {alu_result_in[31:2], 2'b00};
                    mem_wdata_d = read_write_in[3]
                                  ? steer_store(read_write_in[1:0], read_data2_in) : 32'd0;
                    ld_f3_d     = read_write_in[2:0];
                    ld_off_d    = alu_result_in[1:0];
                end else if (valid_c) begin
                    // Misaligned access is dropped; give MEM/WB a clean zero.
                    load_data_d = 32'd0;
                end
            end
            BUSY: begin
                // An ack wins over a coincident timeout.
                if (mem_ack) begin
                    state_d     = DONE;
                    mem_req_d   = 1'b0;
                    load_data_d = mem_we_q ? 32'd0 : extract_load(mem_rdata, ld_f3_q, ld_off_q);
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = DONE;
                    mem_req_d   = 1'b0;
                    load_data_d = 32'd0;
                    bus_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                // EX/MEM advances on this edge, so the access is not re-issued.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            ld_f3_q     <= 3'd0;
            ld_off_q    <= 2'd0;
            load_data_q <= 32'd0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ld_f3_q     <= ld_f3_d;
            ld_off_q    <= ld_off_d;
            load_data_q <= load_data_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_be        = mem_be_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign load_data_out = load_data_q;
    assign bus_error_out = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  read_write_in;
    logic [31:0] alu_result_in;
    logic [31:0] read_data2_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] load_data_out;
    logic        stall_out;
    logic        misalign_out;
    logic        bus_error_out;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .read_write_in (read_write_in),
        .alu_result_in (alu_result_in),
        .read_data2_in (read_data2_in),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .load_data_out (load_data_out),
        .stall_out     (stall_out),
        .misalign_out  (misalign_out),
        .bus_error_out (bus_error_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;
        logic        berr;
        int          reqc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model for randomized accesses.
    function automatic logic [3:0] model_be(input logic [3:0] code, input logic [1:0] off);
        if (code[1:0] == 2'b10) return 4'hF;
        if (code[1:0] == 2'b01) return off[1] ? 4'b1100 : 4'b0011;
        return 4'(1 << off);
    endfunction

    function automatic logic [31:0] model_wd(input logic [3:0] code, input logic [31:0] rs2);
        if (!code[3]) return 32'd0;
        if (code[1:0] == 2'b00) return {rs2[7:0], rs2[7:0], rs2[7:0], rs2[7:0]};
        if (code[1:0] == 2'b01) return {rs2[15:0], rs2[15:0]};
        return rs2;
    endfunction

    function automatic logic [31:0] model_ld(input logic [3:0] code, input logic [1:0] off,
                                             input logic [31:0] rd);
        logic [31:0] v;
        int          sh;
        if (code[3]) return 32'd0;
        sh = 8 * int'(off);
        v  = rd >> sh;
        case (code[2:0])
            3'b000:  return {{24{v[7]}}, v[7:0]};
            3'b100:  return {24'd0, v[7:0]};
            3'b001:  return {{16{v[15]}}, v[15:0]};
            3'b101:  return {16'd0, v[15:0]};
            default: return rd;
        endcase
    endfunction

    // One access: lat = busy-cycle index at which mem_ack is returned
    // (lat >= TO means memory never answers).
    task automatic do_access(input logic [3:0] code, input logic [31:0] addr,
                             input logic [31:0] rs2, input logic [31:0] rdata,
                             input int lat, input logic [3:0] xbe,
                             input logic [31:0] xwd, input logic [31:0] xld);
        exp_t e;
        exp_t g;
        int   reqc;
        int   stc;
        e.addr = {addr[31:2], 2'b00};
        e.we   = code[3];
        e.be   = xbe;
        e.wd   = xwd;
        e.ld   = (lat < TO) ? xld : 32'd0;
        e.berr = (lat >= TO);
        e.reqc = (lat < TO) ? lat + 1 : TO;

        @(negedge clk);
        read_write_in = code;
        alu_result_in = addr;
        read_data2_in = rs2;
        #1;
        check_val("idle_stall", 32'(stall_out), 32'd1);
        check_val("idle_misalign", 32'(misalign_out), 32'd0);
        check_val("idle_req", 32'(mem_req), 32'd0);
        sb.push_back(e);

        reqc = 0;
        stc  = 1;
        g    = e;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            if (k == 0) begin
                g = sb.pop_front();
                check_val("req_addr", mem_addr, g.addr);
                check_val("req_we", 32'(mem_we), 32'(g.we));
                check_val("req_be", 32'(mem_be), 32'(g.be));
                check_val("req_wdata", mem_wdata, g.wd);
            end
            if (mem_req) reqc++;
            if (stall_out) stc++;
            if (k == lat) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
                break;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        check_val("done_req", 32'(mem_req), 32'd0);
        check_val("done_stall", 32'(stall_out), 32'd0);
        check_val("done_load", load_data_out, g.ld);
        check_val("done_berr", 32'(bus_error_out), 32'(g.berr));
        check_val("req_cycles", 32'(reqc), 32'(g.reqc));
        check_val("stall_cycles", 32'(stc), 32'(g.reqc + 1));
        read_write_in = 4'b0011;
        @(negedge clk);
        check_val("after_berr", 32'(bus_error_out), 32'd0);
        check_val("after_req", 32'(mem_req), 32'd0);
        check_val("after_stall", 32'(stall_out), 32'd0);
        check_val("after_load_hold", load_data_out, g.ld);
    endtask

    logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                              4'b0101, 4'b1000, 4'b1001, 4'b1010};

    initial begin
        rst           = 1'b0;
        read_write_in = 4'b0011;
        alu_result_in = 32'd0;
        read_data2_in = 32'd0;
        mem_ack       = 1'b0;
        mem_rdata     = 32'd0;

        repeat (2) @(negedge clk);
        check_val("rst_req", 32'(mem_req), 32'd0);
        check_val("rst_load", load_data_out, 32'd0);
        check_val("rst_berr", 32'(bus_error_out), 32'd0);
        check_val("rst_stall", 32'(stall_out), 32'd0);
        check_val("rst_misalign", 32'(misalign_out), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed accesses
        do_access(4'b0010, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF, 2, 4'b1111, 32'd0, 32'hDEAD_BEEF);
        do_access(4'b0000, 32'h0000_2003, 32'd0, 32'h80FF_0000, 0, 4'b1000, 32'd0, 32'hFFFF_FF80);
        do_access(4'b0100, 32'h0000_2003, 32'd0, 32'h80FF_0000, 1, 4'b1000, 32'd0, 32'h0000_0080);
        do_access(4'b0101, 32'h0000_2002, 32'd0, 32'h80FF_0000, 0, 4'b1100, 32'd0, 32'h0000_80FF);
        do_access(4'b0001, 32'h0000_2002, 32'd0, 32'h80FF_0000, 0, 4'b1100, 32'd0, 32'hFFFF_80FF);
        do_access(4'b1001, 32'h0000_3002, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 4'b1100, 32'hABCD_ABCD, 32'd0);
        do_access(4'b1000, 32'h0000_3001, 32'h0000_0055, 32'd0, 1, 4'b0010, 32'h5555_5555, 32'd0);
        // Ack coincides with the last allowed cycle: success, no bus error.
        do_access(4'b1010, 32'h0000_3008, 32'h0BAD_CAFE, 32'd0, TO - 1, 4'b1111, 32'h0BAD_CAFE, 32'd0);
        do_access(4'b0010, 32'h0000_0020, 32'd0, 32'h1234_5678, 1, 4'b1111, 32'd0, 32'h1234_5678);
        // Unresponsive memory: abort with bus error.
        do_access(4'b0010, 32'h0000_0030, 32'd0, 32'hAAAA_AAAA, 99, 4'b1111, 32'd0, 32'd0);

        // Misaligned access after a nonzero load result
        do_access(4'b0010, 32'h0000_0040, 32'd0, 32'h1357_9BDF, 0, 4'b1111, 32'd0, 32'h1357_9BDF);
        @(negedge clk);
        read_write_in = 4'b0010;
        alu_result_in = 32'h0000_0041;
        #1;
        check_val("mis_flag", 32'(misalign_out), 32'd1);
        check_val("mis_stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        check_val("mis_req", 32'(mem_req), 32'd0);
        check_val("mis_load", load_data_out, 32'd0);
        read_write_in = 4'b0011;
        #1;
        check_val("nop_misalign", 32'(misalign_out), 32'd0);
        check_val("nop_stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        check_val("nop_req", 32'(mem_req), 32'd0);

        // Randomized aligned accesses checked against the model
        for (int i = 0; i < 12; i++) begin
            logic [3:0]  c;
            logic [31:0] a;
            logic [31:0] r2;
            logic [31:0] rd;
            int          lt;
            c  = codes[$urandom_range(0, 7)];
            a  = $urandom;
            if (c[1:0] == 2'b01) a[0] = 1'b0;
            if (c[1:0] == 2'b10) a[1:0] = 2'b00;
            r2 = $urandom;
            rd = $urandom;
            lt = $urandom_range(0, TO - 1);
            do_access(c, a, r2, rd, lt, model_be(c, a[1:0]), model_wd(c, r2), model_ld(c, a[1:0], rd));
        end

        // Reset in the middle of a transaction
        do_access(4'b0010, 32'h0000_0044, 32'd0, 32'hCAFE_F00D, 0, 4'b1111, 32'd0, 32'hCAFE_F00D);
        @(negedge clk);
        read_write_in = 4'b1010;
        alu_result_in = 32'h0000_0048;
        read_data2_in = 32'h7777_7777;
        @(negedge clk);
        check_val("pre_rst_req", 32'(mem_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_req", 32'(mem_req), 32'd0);
        check_val("arst_we", 32'(mem_we), 32'd0);
        check_val("arst_be", 32'(mem_be), 32'd0);
        check_val("arst_addr", mem_addr, 32'd0);
        check_val("arst_wdata", mem_wdata, 32'd0);
        check_val("arst_load", load_data_out, 32'd0);
        read_write_in = 4'b0011;
        #1;
        check_val("arst_stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        check_val("late_ack_req", 32'(mem_req), 32'd0);
        check_val("late_ack_load", load_data_out, 32'd0);
        check_val("late_ack_stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        check_val("late_ack_berr", 32'(bus_error_out), 32'd0);
        check_val("late_ack_load2", load_data_out, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
